// File: rtl/aes_byte_loader.sv
// aes_byte_loader
// Collects 16-byte frames from an 8-bit valid/ready stream into a key or a
// plaintext register. A completed plaintext frame, with a key already loaded,
// fires a one-cycle start to the AES core. The loader then blocks input until
// the core reports done, or until a timeout aborts the operation with an error.
module aes_byte_loader #(
    parameter int DONE_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [7:0]   iByteData,
    input  logic         iByteValid,
    input  logic         iIsKey,
    output logic         oByteReady,
    output logic [127:0] oKey,
    output logic [127:0] oPlaintext,
    output logic         oKeyValid,
    output logic         oStart,
    input  logic         iDone,
    output logic         oBusy,
    output logic         oError
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(DONE_TIMEOUT - 1);

    state_t           state;
    logic [3:0]       byte_cnt;
    logic             frame_is_key;
    logic [CNT_W-1:0] wait_cnt;

    logic             accept;
    logic             tgt_key;
    logic [3:0]       lane;

    // Handshake and busy flags are decoded straight from the state so that
    // input is blocked in the same cycle the loader leaves COLLECT.
    assign oByteReady = (state == S_IDLE) || (state == S_COLLECT);
    assign oBusy      = (state == S_START) || (state == S_WAIT);
    assign accept     = iByteValid && oByteReady;

    // Frame type comes from iIsKey only on the first byte; afterwards the
    // latched type steers the remaining bytes.
    assign tgt_key    = (state == S_IDLE) ? iIsKey : frame_is_key;

    // Byte k of a frame lands in lane 15-k, so byte 0 is the most significant.
    assign lane       = 4'd15 - byte_cnt;

    // Frame assembly, start/error pulses and core hand-off sequencing.
    // NOTE: every register here is assigned with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            // NOTE: the wide data registers are reset too, because a reset must
            // discard a loaded key rather than leave it usable.
            state        <= S_IDLE;
            byte_cnt     <= '0;
            frame_is_key <= 1'b0;
            wait_cnt     <= '0;
            oKey         <= '0;
            oPlaintext   <= '0;
            oKeyValid    <= 1'b0;
            oStart       <= 1'b0;
            oError       <= 1'b0;
        end else begin
            oStart <= 1'b0;
            oError <= 1'b0;

            if (accept) begin
                if (tgt_key) begin
                    oKey[{lane, 3'b000} +: 8] <= iByteData;
                end else begin
                    oPlaintext[{lane, 3'b000} +: 8] <= iByteData;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        frame_is_key <= iIsKey;
                        byte_cnt     <= 4'd1;
                        state        <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (accept) begin
                        if (byte_cnt == 4'd15) begin
                            byte_cnt <= '0;
                            if (frame_is_key) begin
                                oKeyValid <= 1'b1;
                                state     <= S_IDLE;
                            end else if (oKeyValid) begin
                                oStart <= 1'b1;
                                state  <= S_START;
                            end else begin
                                // Plaintext without a key cannot be encrypted.
                                oError <= 1'b1;
                                state  <= S_IDLE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end

                S_START: begin
                    // iDone may still be high from the previous operation,
                    // so it is not looked at until WAIT.
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (iDone) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        oError <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Testbench for aes_byte_loader: random byte streams with bubbles, a simple
// core model driving iDone, and a scoreboard of expected start/error pulses.
module tb_aes_byte_loader;

    localparam int T = 64;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic [7:0]   iByteData = '0;
    logic         iByteValid = 1'b0;
    logic         iIsKey = 1'b0;
    logic         iDone = 1'b1;
    logic         oByteReady;
    logic [127:0] oKey;
    logic [127:0] oPlaintext;
    logic         oKeyValid;
    logic         oStart;
    logic         oBusy;
    logic         oError;

    aes_byte_loader #(.DONE_TIMEOUT(T), .CNT_W(16)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iByteData  (iByteData),
        .iByteValid (iByteValid),
        .iIsKey     (iIsKey),
        .oByteReady (oByteReady),
        .oKey       (oKey),
        .oPlaintext (oPlaintext),
        .oKeyValid  (oKeyValid),
        .oStart     (oStart),
        .iDone      (iDone),
        .oBusy      (oBusy),
        .oError     (oError)
    );

    always #5 iClk = ~iClk;

    // cyc equals the index of the most recent rising edge.
    int unsigned cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard entries: which pulse, at which cycle, with which operands.
    localparam int EV_START = 0;
    localparam int EV_ERROR = 1;
    typedef struct {
        int          kind;
        int unsigned at;
        logic [127:0] key;
        logic [127:0] pt;
    } ev_t;
    ev_t exp_q[$];

    // Reference model state: what the loader should hold.
    logic [127:0] m_key = '0;
    logic [127:0] m_pt  = '0;
    logic         m_kv  = 1'b0;

    // Core behaviour: 0 = never raise done, -1 = random 1..20, else fixed latency.
    int core_lat = -1;

    // Core model: done stays high until the cycle after a start, then rises
    // again after the chosen latency.
    initial begin
        int lat;
        forever begin
            @(negedge iClk);
            if (oStart && !iRst) begin
                lat = (core_lat < 0) ? int'($urandom_range(1, 20)) : core_lat;
                @(negedge iClk);
                iDone = 1'b0;
                if (lat > 0) begin
                    repeat (lat) @(negedge iClk);
                    iDone = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every pulse and checks operands are
    // held stable for the whole operation.
    ev_t          mon_e;
    logic         in_op = 1'b0;
    logic [127:0] hold_key, hold_pt;
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oStart || oError) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: start=%b error=%b at cycle %0d, none expected",
                             oStart, oError, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", {oError, oStart}, (mon_e.kind == EV_START) ? 2'b01 : 2'b10);
                    check("pulse_cycle", cyc, mon_e.at);
                    if (mon_e.kind == EV_START) begin
                        check("start_key", oKey, mon_e.key);
                        check("start_pt", oPlaintext, mon_e.pt);
                        check("start_busy", oBusy, 1'b1);
                        check("start_ready", oByteReady, 1'b0);
                        hold_key = mon_e.key;
                        hold_pt  = mon_e.pt;
                        in_op    = 1'b1;
                    end
                end
            end else if (in_op) begin
                if (oBusy) begin
                    check("busy_ready_low", oByteReady, 1'b0);
                    check("busy_key_stable", oKey, hold_key);
                    check("busy_pt_stable", oPlaintext, hold_pt);
                end else begin
                    in_op = 1'b0;
                end
            end
        end
    end

    // Present one byte with random bubbles; returns the edge it was accepted on.
    task automatic send_byte(input logic [7:0] b, input logic k, output int unsigned at);
        int waited;
        waited = 0;
        at = 0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge iClk);
            iByteValid = 1'b0;
            iByteData  = 8'($urandom);
            iIsKey     = 1'($urandom);
        end
        @(negedge iClk);
        iByteValid = 1'b1;
        iByteData  = b;
        iIsKey     = k;
        while (!oByteReady) begin
            @(negedge iClk);
            waited++;
            if (waited > 500) begin
                checks++;
                failures++;
                $display("FAIL byte_accept_timeout: ready stayed 0 for %0d cycles, required 1", waited);
                iByteValid = 1'b0;
                return;
            end
        end
        at = cyc + 1;
        @(posedge iClk);
        #1;
        iByteValid = 1'b0;
        iByteData  = 8'($urandom);
    endtask

    // Send the first n bytes of a frame and predict the outcome.
    task automatic send_frame(input logic is_key, input logic [127:0] frame, input int n);
        int unsigned a;
        logic        k_b;
        logic [7:0]  b;
        ev_t         e;
        a = 0;
        for (int k = 0; k < n; k++) begin
            b   = frame[8*(15-k) +: 8];
            k_b = (k == 0) ? is_key : 1'($urandom_range(0, 1));
            send_byte(b, k_b, a);
            if (is_key) m_key[8*(15-k) +: 8] = b;
            else        m_pt[8*(15-k) +: 8]  = b;
        end
        if (n == 16) begin
            if (is_key) begin
                m_kv = 1'b1;
                @(negedge iClk);
                check("key_value", oKey, m_key);
                check("key_valid", oKeyValid, 1'b1);
                check("key_ready", oByteReady, 1'b1);
            end else begin
                e.key = m_key;
                e.pt  = m_pt;
                if (m_kv) begin
                    e.kind = EV_START;
                    e.at   = a;
                    exp_q.push_back(e);
                    if (core_lat == 0 || core_lat >= T) begin
                        e.kind = EV_ERROR;
                        e.at   = a + 1 + T;
                        exp_q.push_back(e);
                    end
                end else begin
                    e.kind = EV_ERROR;
                    e.at   = a;
                    exp_q.push_back(e);
                end
                @(negedge iClk);
                check("pt_value", oPlaintext, m_pt);
            end
        end
    endtask

    // Assert reset between edges and confirm everything clears at once.
    task automatic async_reset();
        @(negedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        check("rst_key", oKey, 128'h0);
        check("rst_pt", oPlaintext, 128'h0);
        check("rst_flags", {oKeyValid, oStart, oError, oBusy}, 4'b0000);
        m_key = '0;
        m_pt  = '0;
        m_kv  = 1'b0;
        exp_q.delete();
        in_op      = 1'b0;
        iByteValid = 1'b0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        #1;
        check("rst_ready", oByteReady, 1'b1);
    endtask

    initial begin
        logic [127:0] fr;

        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        #1;
        check("init_key", oKey, 128'h0);
        check("init_pt", oPlaintext, 128'h0);
        check("init_flags", {oKeyValid, oStart, oError, oBusy}, 4'b0000);
        check("init_ready", oByteReady, 1'b1);

        // Known key and plaintext frames.
        core_lat = -1;
        send_frame(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 16);
        send_frame(1'b0, 128'h00112233445566778899aabbccddeeff, 16);

        // Done arriving on the very timeout cycle wins; one cycle later loses.
        core_lat = T - 1;
        send_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16);
        core_lat = T;
        send_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16);
        // Done never returns: timeout error.
        core_lat = 0;
        send_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16);
        core_lat = -1;

        // Random mix of key reloads and encryptions.
        for (int i = 0; i < 8; i++) begin
            fr = {$urandom, $urandom, $urandom, $urandom};
            send_frame(1'($urandom_range(0, 1)), fr, 16);
        end

        // Reset after byte 7 of a key frame.
        send_frame(1'b1, {$urandom, $urandom, $urandom, $urandom}, 8);
        async_reset();

        // Key was discarded: plaintext now errors; then a fresh key loads from byte 0.
        send_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16);
        send_frame(1'b1, {$urandom, $urandom, $urandom, $urandom}, 16);

        // Reset in the middle of WAIT.
        core_lat = 0;
        send_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16);
        repeat (5) @(negedge iClk);
        check("wait_busy_before_rst", oBusy, 1'b1);
        async_reset();
        core_lat = -1;
        send_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16);

        // Drain outstanding expectations within a bounded time.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge iClk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
